kamikaze_writeback: RTL
=======================

KAMIKAZE_WRITEBACK -- requirements
Module: kamikaze_writeback

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports clk_i and rst_i.
REQ-002 clk_i  in  1  core clock; all state updates on its rising edge.
REQ-003 rst_i  in  1  reset, asynchronous, active-high.
REQ-004 alu_valid_i  in  1 / alu_rd_i  in  5 / alu_data_i  in  32  single-cycle ALU result.
REQ-005 alu_ready_o  out  1  ALU result accepted this cycle.
REQ-006 lsu_valid_i  in  1 / lsu_rd_i  in  5 / lsu_data_i  in  32  load result.
REQ-007 lsu_ready_o  out  1  load result accepted this cycle.
REQ-008 pend_set_i  in  1 / pend_rd_i  in  5  mark a register as awaiting a load result, at load issue.
REQ-009 rs1_i, rs2_i  in  5 each  decode-stage source register indices.
REQ-010 hazard_o  out  1  a source register has a pending load.
REQ-011 byp1_o, byp2_o  out  1 each / bypd1_o, bypd2_o  out  32 each  bypass hit and bypass data per source.
REQ-012 we_o  out  1 / waddr_o  out  5 / wdata_o  out  32  register-file write port, registered.

Function
REQ-013 A handshake SHALL complete on any rising edge where valid and ready are both 1.
REQ-014 Hold buffer: one entry holding rd and data, with hold_valid; write-port priority SHALL be hold buffer > ALU > LSU.
REQ-015 alu_ready_o SHALL equal !hold_valid.
REQ-016 lsu_ready_o SHALL equal !hold_valid.
REQ-017 ALU-only accept: write port loads the ALU rd/data next cycle; latency 1 cycle.
REQ-018 LSU-only accept (no ALU valid, hold empty): write port loads the LSU rd/data next cycle; latency 1 cycle.
REQ-019 ALU and LSU accepted in the same cycle: the ALU result goes to the write port; the LSU result goes into the hold buffer.
REQ-020 Hold valid: the hold entry goes to the write port and hold_valid clears, in the same edge; no new input is accepted that cycle.
REQ-021 No source active: we_o SHALL be 0 next cycle; waddr_o/wdata_o hold their previous values.
REQ-022 Register 0: a result with rd==0 SHALL complete its handshake but drive we_o=0.
REQ-023 Scoreboard: 32-bit pending vector; bit 0 SHALL always read 0.
REQ-024 The pending bit for pend_rd_i SHALL be set on the edge where pend_set_i=1 (ignored if rd==0).
REQ-025 A pending bit SHALL clear when the LSU result for that rd is written (we_o edge sourced from LSU or hold).
REQ-026 Simultaneous set and clear of the same rd: set SHALL win.
REQ-027 hazard_o SHALL equal pending[rs1_i] | pending[rs2_i], combinational.
REQ-028 byp1_o SHALL be 1 when we_o=1 and waddr_o==rs1_i!=0, with bypd1_o=wdata_o; likewise byp2_o/bypd2_o for rs2_i.
REQ-029 bypd1_o and bypd2_o SHALL be 0 when not hitting.

Reset
REQ-030 On rst_i assertion, immediately and independent of clk_i: we_o=0, waddr_o=0, wdata_o=0, hold_valid=0, all pending bits=0.
REQ-031 Reset mid-operation SHALL discard the hold entry and all pending marks; no write SHALL issue after reset.
REQ-032 During reset: alu_ready_o=1, lsu_ready_o=1, hazard_o=0, byp1_o=byp2_o=0.

Structure
REQ-033 kamikaze_pkg SHALL hold XLEN=32, REG_AW=5, REG_NUM=32, and the write-source enum {SRC_NONE, SRC_ALU, SRC_LSU, SRC_HOLD}.
REQ-034 The pending vector and hazard logic SHALL be sub-module kamikaze_wb_scoreboard; arbitration and hold buffer stay at top level.

Verification
REQ-035 ALU rd=5 data=0x12345678 alone -> next cycle we_o=1, waddr_o=5, wdata_o=0x12345678, byp1_o=1 when rs1_i=5.
REQ-036 ALU rd=3 data=0xA, LSU rd=7 data=0xB same cycle -> cycle+1 writes r3=0xA; cycle+2 writes r7=0xB; ready outputs 0 during cycle+1.
REQ-037 pend_set_i rd=9 -> hazard_o=1 with rs2_i=9 until LSU rd=9 is written; hazard_o=0 on the following cycle.
REQ-038 ALU rd=0 data=0xFFFFFFFF -> alu_ready_o=1, we_o stays 0; rs1_i=0 gives byp1_o=0.
REQ-039 pend_set_i rd=4 on the same edge as LSU write of rd=4 -> pending[4] remains 1 and hazard_o=1 for rs1_i=4.
REQ-040 Assert rst_i while the hold buffer is full and rd=6 is pending -> we_o=0 immediately, no write of the held data after release, hazard_o=0.

Source files
------------

// File: rtl/kamikaze_pkg.sv
// Shared widths, write-source encoding and result payload for the writeback stage.
package kamikaze_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned REG_AW  = 5;
  localparam int unsigned REG_NUM = 32;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_ALU,
    SRC_LSU,
    SRC_HOLD
  } wb_src_e;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;

endpackage

// File: rtl/kamikaze_wb_scoreboard.sv
// Pending-load scoreboard: one bit per architectural register, r0 hardwired clear.
module kamikaze_wb_scoreboard
  import kamikaze_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              set_i,
  input  logic [REG_AW-1:0] set_rd_i,
  input  logic              clr_i,
  input  logic [REG_AW-1:0] clr_rd_i,
  input  logic [REG_AW-1:0] rs1_i,
  input  logic [REG_AW-1:0] rs2_i,
  output logic              hazard_o
);

  logic [REG_NUM-1:0] pending_q;
  logic [REG_NUM-1:0] pending_d;

  // Clear first so a set on the same register in the same cycle wins.
  always_comb begin
    pending_d = pending_q;
    if (clr_i) begin
      pending_d[clr_rd_i] = 1'b0;
    end
    if (set_i && (set_rd_i != '0)) begin
      pending_d[set_rd_i] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign hazard_o = pending_q[rs1_i] | pending_q[rs2_i];

endmodule

// File: rtl/kamikaze_writeback.sv
// Writeback arbiter: merges ALU and load results onto one register-file write port,
// parking a colliding load result in a single hold entry, with bypass and load hazards.
module kamikaze_writeback
  import kamikaze_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              alu_valid_i,
  input  logic [REG_AW-1:0] alu_rd_i,
  input  logic [XLEN-1:0]   alu_data_i,
  output logic              alu_ready_o,
  input  logic              lsu_valid_i,
  input  logic [REG_AW-1:0] lsu_rd_i,
  input  logic [XLEN-1:0]   lsu_data_i,
  output logic              lsu_ready_o,
  input  logic              pend_set_i,
  input  logic [REG_AW-1:0] pend_rd_i,
  input  logic [REG_AW-1:0] rs1_i,
  input  logic [REG_AW-1:0] rs2_i,
  output logic              hazard_o,
  output logic              byp1_o,
  output logic              byp2_o,
  output logic [XLEN-1:0]   bypd1_o,
  output logic [XLEN-1:0]   bypd2_o,
  output logic              we_o,
  output logic [REG_AW-1:0] waddr_o,
  output logic [XLEN-1:0]   wdata_o
);

  logic              hold_valid_q, hold_valid_d;
  wb_entry_t         hold_q, hold_d;
  logic              we_q, we_d;
  logic [REG_AW-1:0] waddr_q, waddr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  wb_src_e           src;
  wb_entry_t         sel;
  logic              clr_en;

  assign alu_ready_o = ~hold_valid_q;
  assign lsu_ready_o = ~hold_valid_q;

  // Priority hold > ALU > LSU; a full hold entry blocks all new results.
  always_comb begin
    src          = SRC_NONE;
    sel          = '0;
    hold_valid_d = hold_valid_q;
    hold_d       = hold_q;
    if (hold_valid_q) begin
      src          = SRC_HOLD;
      sel          = hold_q;
      hold_valid_d = 1'b0;
    end else if (alu_valid_i) begin
      src = SRC_ALU;
      sel = '{rd: alu_rd_i, data: alu_data_i};
      if (lsu_valid_i) begin
        hold_valid_d = 1'b1;
        hold_d       = '{rd: lsu_rd_i, data: lsu_data_i};
      end
    end else if (lsu_valid_i) begin
      src = SRC_LSU;
      sel = '{rd: lsu_rd_i, data: lsu_data_i};
    end
    we_d    = (src != SRC_NONE) && (sel.rd != '0);
    waddr_d = we_d ? sel.rd : waddr_q;
    wdata_d = we_d ? sel.data : wdata_q;
    clr_en  = we_d && ((src == SRC_LSU) || (src == SRC_HOLD));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hold_valid_q <= 1'b0;
      hold_q       <= '0;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_q       <= hold_d;
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
    end
  end

  kamikaze_wb_scoreboard u_scoreboard (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .set_i    (pend_set_i),
    .set_rd_i (pend_rd_i),
    .clr_i    (clr_en),
    .clr_rd_i (sel.rd),
    .rs1_i    (rs1_i),
    .rs2_i    (rs2_i),
    .hazard_o (hazard_o)
  );

  assign we_o    = we_q;
  assign waddr_o = waddr_q;
  assign wdata_o = wdata_q;

  // Forward the value being written this cycle; r0 never forwards.
  assign byp1_o  = we_q && (waddr_q == rs1_i) && (rs1_i != '0);
  assign byp2_o  = we_q && (waddr_q == rs2_i) && (rs2_i != '0);
  assign bypd1_o = byp1_o ? wdata_q : '0;
  assign bypd2_o = byp2_o ? wdata_q : '0;

endmodule
